// File: rtl/serv_alu_seq.sv
// serv_alu_seq -- sequencer that feeds a bit-serial ALU from parallel words.
//
// Accepts a request carrying two parallel operands, streams them LSB first
// to the serial ALU (optionally with an init pass before the run pass),
// gathers the serial result back into a parallel word and holds it until
// the consumer takes it.
//
// Ports
//   clk          clock, all state on the rising edge
//   i_rst        asynchronous active-high reset
//   i_req_valid  request valid
//   o_req_ready  high only while idle
//   i_rs1_word   parallel rs1 operand
//   i_op_b_word  parallel op_b operand
//   i_two_phase  request needs an init pass before the run pass
//   o_en         ALU enable (init and run passes)
//   o_rs1        serial rs1 bit, LSB first
//   o_op_b       serial op_b bit, LSB first
//   o_init       init pass active
//   o_cnt_done   last bit of the current pass
//   i_rd         serial result bit from the ALU
//   o_res_valid  collected result word valid
//   i_res_ready  consumer accepts the result
//   o_res_word   collected parallel result
module serv_alu_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [DATA_W-1:0] i_rs1_word,
  input  logic [DATA_W-1:0] i_op_b_word,
  input  logic              i_two_phase,
  output logic              o_en,
  output logic              o_rs1,
  output logic              o_op_b,
  output logic              o_init,
  output logic              o_cnt_done,
  input  logic              i_rd,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [DATA_W-1:0] o_res_word
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  rs1_q;
  logic [DATA_W-1:0]  opb_q;
  logic [DATA_W-1:0]  res_q;
  logic               last_bit;

  assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rs1_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req_valid) begin
            rs1_q   <= i_rs1_word;
            opb_q   <= i_op_b_word;
            cnt_q   <= '0;
            state_q <= i_two_phase ? INIT : RUN;
          end
        end
        INIT: begin
          // Rotate rather than shift so the run pass sees the same words again.
          rs1_q <= {rs1_q[0], rs1_q[DATA_W-1:1]};
          opb_q <= {opb_q[0], opb_q[DATA_W-1:1]};
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          rs1_q <= {rs1_q[0], rs1_q[DATA_W-1:1]};
          opb_q <= {opb_q[0], opb_q[DATA_W-1:1]};
          // Result enters at the top so the first run bit lands at bit 0.
          res_q <= {i_rd, res_q[DATA_W-1:1]};
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (i_res_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_req_ready = (state_q == IDLE);
  assign o_en        = (state_q == INIT) || (state_q == RUN);
  assign o_init      = (state_q == INIT);
  assign o_cnt_done  = o_en && last_bit;
  assign o_rs1       = rs1_q[0];
  assign o_op_b      = opb_q[0];
  assign o_res_valid = (state_q == DONE);
  assign o_res_word  = res_q;

endmodule
